// File: rtl/apu_reg_writer_pkg.sv
// ---------------------------------------------------------------------------
// apu_reg_writer_pkg
//   Shared types and field positions for the APU host command stream.
//   Command frame = header byte {1, d7, 0, 0, ch[1:0], r[1:0]} followed by a
//   data byte {0, d[6:0]}; the written value is {d7, d[6:0]}.
// ---------------------------------------------------------------------------
package apu_reg_writer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        COMMIT    = 2'd2
    } state_e;

    localparam int HDR_SYNC    = 7;   // 1 = header, 0 = data
    localparam int HDR_D7      = 6;   // bit 7 of the value being written
    localparam int HDR_RSVD_HI = 5;
    localparam int HDR_RSVD_LO = 4;
    localparam int HDR_CH_HI   = 3;
    localparam int HDR_CH_LO   = 2;
    localparam int HDR_REG_HI  = 1;
    localparam int HDR_REG_LO  = 0;

    // Writes to this register index are announced to the channel via reg_change.
    localparam logic [1:0] REG_TRIGGER = 2'd3;

    // A header is usable only when the reserved bits are clear and the
    // addressed channel exists.
    function automatic logic hdr_valid(input logic [7:0] b, input int unsigned nchan);
        return (b[HDR_RSVD_HI:HDR_RSVD_LO] == 2'b00) &&
               (32'(b[HDR_CH_HI:HDR_CH_LO]) < nchan);
    endfunction

endpackage

// File: rtl/apu_reg_writer_parser.sv
// ---------------------------------------------------------------------------
// apu_cmd_parser
//   Command stream decoder: IDLE / WAIT_DATA / COMMIT state machine, the
//   header-to-data timeout counter and protocol error detection.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     rx_data_i       received byte
//     rx_valid_i      one-cycle strobe qualifying rx_data_i
//     wr_en_o         register write this cycle (data byte accepted)
//     wr_ch_o/reg_o   write address
//     wr_val_o        write value {d7, d[6:0]}
//     trig_o          COMMIT of a REG_TRIGGER write: toggle reg_change on this edge
//     trig_ch_o       channel to toggle
//     err_inc_o       number of protocol errors detected this cycle (0..2)
// ---------------------------------------------------------------------------
module apu_cmd_parser
    import apu_reg_writer_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       wr_en_o,
    output logic [1:0] wr_ch_o,
    output logic [1:0] wr_reg_o,
    output logic [7:0] wr_val_o,
    output logic       trig_o,
    output logic [1:0] trig_ch_o,
    output logic [1:0] err_inc_o
);

    state_e      state_q, state_d;
    logic        d7_q, d7_d;
    logic [1:0]  ch_q, ch_d;
    logic [1:0]  r_q, r_d;
    logic [15:0] cnt_q, cnt_d;

    logic byte_hdr;
    logic byte_dat;
    logic hdr_ok;

    assign byte_hdr = rx_valid_i &&  rx_data_i[HDR_SYNC];
    assign byte_dat = rx_valid_i && !rx_data_i[HDR_SYNC];
    assign hdr_ok   = hdr_valid(rx_data_i, NUM_CHAN);

    // The write is decoded combinationally so regs_out lands on the edge that
    // leaves WAIT_DATA; the toggle then follows one edge later from COMMIT,
    // giving the channel a full cycle of stable data before it sees the edge.
    assign wr_ch_o   = ch_q;
    assign wr_reg_o  = r_q;
    assign wr_val_o  = {d7_q, rx_data_i[6:0]};
    assign trig_o    = (state_q == COMMIT) && (r_q == REG_TRIGGER);
    assign trig_ch_o = ch_q;

    always_comb begin
        state_d   = state_q;
        d7_d      = d7_q;
        ch_d      = ch_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        wr_en_o   = 1'b0;
        err_inc_o = 2'd0;

        case (state_q)
            WAIT_DATA: begin
                if (byte_dat) begin
                    wr_en_o = 1'b1;
                    state_d = COMMIT;
                end else if (!rx_valid_i) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == 16'(TIMEOUT)) begin
                        err_inc_o = 2'd1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                // IDLE and COMMIT share the same byte handling, so a byte
                // arriving during COMMIT is never lost.
                state_d = IDLE;
                if (byte_dat) begin
                    err_inc_o = 2'd1;
                end
            end
        endcase

        // Headers restart framing from any state. An interrupted frame costs
        // one error, an unusable header costs another.
        if (byte_hdr) begin
            err_inc_o = {1'b0, state_q == WAIT_DATA} + {1'b0, !hdr_ok};
            if (hdr_ok) begin
                d7_d    = rx_data_i[HDR_D7];
                ch_d    = rx_data_i[HDR_CH_HI:HDR_CH_LO];
                r_d     = rx_data_i[HDR_REG_HI:HDR_REG_LO];
                cnt_d   = 16'd0;
                state_d = WAIT_DATA;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d7_q    <= 1'b0;
            ch_q    <= 2'd0;
            r_q     <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            d7_q    <= d7_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/apu_reg_writer.sv
// ---------------------------------------------------------------------------
// apu_reg_writer
//   Host-side register file for the sound channels. Decodes the 2-byte
//   command stream (apu_cmd_parser) and holds four 8-bit registers per
//   channel, a per-channel reg_change toggle and a saturating error count.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     rx_data      received byte
//     rx_valid     one-cycle strobe qualifying rx_data
//     regs_out     channel c, register r at [c*32 + r*8 +: 8]
//     reg_change   per-channel toggle, flips once per committed register-3 write
//     err_count    saturating protocol error count
//
//   NUM_CHAN must be 1..4 (2-bit channel field); TIMEOUT must be 1..65535.
// ---------------------------------------------------------------------------
module apu_reg_writer
    import apu_reg_writer_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [NUM_CHAN*32-1:0]  regs_out,
    output logic [NUM_CHAN-1:0]     reg_change,
    output logic [7:0]              err_count
);

    logic       wr_en;
    logic [1:0] wr_ch;
    logic [1:0] wr_reg;
    logic [7:0] wr_val;
    logic       trig;
    logic [1:0] trig_ch;
    logic [1:0] err_inc;

    logic [NUM_CHAN*32-1:0] regs_q;
    logic [NUM_CHAN-1:0]    chg_q;
    logic [7:0]             err_q, err_d;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    apu_cmd_parser #(
        .NUM_CHAN (NUM_CHAN),
        .TIMEOUT  (TIMEOUT)
    ) u_parser (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .wr_en_o    (wr_en),
        .wr_ch_o    (wr_ch),
        .wr_reg_o   (wr_reg),
        .wr_val_o   (wr_val),
        .trig_o     (trig),
        .trig_ch_o  (trig_ch),
        .err_inc_o  (err_inc)
    );

    assign err_d = sat_add8(err_q, err_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            chg_q  <= '0;
            err_q  <= 8'd0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (wr_en && (wr_ch == 2'(c)) && (wr_reg == 2'(r))) begin
                        regs_q[c*32 + r*8 +: 8] <= wr_val;
                    end
                end
                if (trig && (trig_ch == 2'(c))) begin
                    chg_q[c] <= ~chg_q[c];
                end
            end
            err_q <= err_d;
        end
    end

    assign regs_out   = regs_q;
    assign reg_change = chg_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
module tb_apu_reg_writer;

    localparam int NC = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [NC*32-1:0]  regs_out;
    logic [NC-1:0]     reg_change;
    logic [7:0]        err_count;

    int total = 0;
    int bad   = 0;

    apu_reg_writer #(.NUM_CHAN(NC), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .regs_out   (regs_out),
        .reg_change (reg_change),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame-level) ----------------
    logic [7:0]    m_regs [NC][4];
    logic [NC-1:0] m_chg;
    int            m_err;
    bit            m_have;      // a header is waiting for its data byte
    bit            m_d7;
    int            m_ch, m_r, m_age;
    bit            m_pend;      // register-3 write done, toggle due next cycle
    int            m_pend_ch;

    function automatic logic [NC*32-1:0] exp_regs();
        logic [NC*32-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 4; r++)
                v[c*32 + r*8 +: 8] = m_regs[c][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 4; r++)
                m_regs[c][r] = 8'h00;
        m_chg = '0; m_err = 0; m_have = 0; m_d7 = 0;
        m_ch = 0; m_r = 0; m_age = 0; m_pend = 0; m_pend_ch = 0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        if (m_pend) m_chg[m_pend_ch] = ~m_chg[m_pend_ch];
        m_pend = 0;
        if (v && b[7]) begin
            if (m_have) model_err();
            if (b[5:4] == 2'b00 && int'(b[3:2]) < NC) begin
                m_have = 1; m_d7 = b[6]; m_ch = int'(b[3:2]); m_r = int'(b[1:0]); m_age = 0;
            end else begin
                model_err(); m_have = 0;
            end
        end else if (v) begin
            if (m_have) begin
                m_regs[m_ch][m_r] = {m_d7, b[6:0]};
                if (m_r == 3) begin m_pend = 1; m_pend_ch = m_ch; end
                m_have = 0;
            end else begin
                model_err();
            end
        end else if (m_have) begin
            m_age++;
            if (m_age == TO) begin model_err(); m_have = 0; end
        end
    endtask

    // One clock cycle: drive, clock, advance the model, settle 1 time unit.
    task automatic tick(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        @(posedge clk);
        model_step(v, b);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        @(posedge clk); #1;
        total++; if (regs_out !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs_out); end
        total++; if (reg_change !== '0) begin bad++; $display("FAIL reset_chg got=%b exp=0", reg_change); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        do_reset();
        tick(1, 8'hC6); tick(0, 0); tick(1, 8'h25);
        total++; if (regs_out[55:48] !== 8'hA5) begin bad++; $display("FAIL basic_reg got=%h exp=a5", regs_out[55:48]); end
        tick(0, 0); tick(0, 0);
        total++; if (regs_out !== exp_regs()) begin bad++; $display("FAIL basic_all got=%h exp=%h", regs_out, exp_regs()); end
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL basic_chg got=%b exp=00", reg_change); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL basic_err got=%0d exp=0", err_count); end
    endtask

    task automatic test_trigger();
        do_reset();
        tick(1, 8'h83); tick(0, 0); tick(1, 8'h08);
        total++; if (regs_out[31:24] !== 8'h08) begin bad++; $display("FAIL trig_reg got=%h exp=08", regs_out[31:24]); end
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL trig_early got=%b exp=00", reg_change); end
        tick(0, 0);
        total++; if (reg_change !== 2'b01) begin bad++; $display("FAIL trig_edge got=%b exp=01", reg_change); end
        tick(0, 0);
        tick(1, 8'h83); tick(0, 0); tick(1, 8'h08); tick(0, 0); tick(0, 0);
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL trig_back got=%b exp=00", reg_change); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL trig_err got=%0d exp=0", err_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // second header lands in the COMMIT cycle of the first frame
        tick(1, 8'h87); tick(0, 0); tick(1, 8'h11); tick(1, 8'hC7); tick(0, 0); tick(1, 8'h22);
        tick(0, 0); tick(0, 0);
        total++; if (regs_out[63:56] !== 8'hA2) begin bad++; $display("FAIL b2b_reg got=%h exp=a2", regs_out[63:56]); end
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL b2b_chg got=%b exp=00", reg_change); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err_count); end
    endtask

    task automatic test_restart();
        do_reset();
        tick(1, 8'h12); tick(0, 0); tick(1, 8'h81); tick(0, 0);
        tick(1, 8'h82); tick(0, 0); tick(1, 8'h7F); tick(0, 0); tick(0, 0);
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL restart_err got=%0d exp=2", err_count); end
        total++; if (regs_out[23:16] !== 8'h7F) begin bad++; $display("FAIL restart_reg2 got=%h exp=7f", regs_out[23:16]); end
        total++; if (regs_out[15:8] !== 8'h00) begin bad++; $display("FAIL restart_reg1 got=%h exp=00", regs_out[15:8]); end
        total++; if (regs_out !== exp_regs()) begin bad++; $display("FAIL restart_all got=%h exp=%h", regs_out, exp_regs()); end
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1, 8'h80);
        for (int i = 0; i < TO - 1; i++) tick(0, 0);
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", err_count); end
        tick(0, 0);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL tmo_fire got=%0d exp=1", err_count); end
        tick(1, 8'h55); tick(0, 0);
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL tmo_err got=%0d exp=2", err_count); end
        total++; if (regs_out !== '0) begin bad++; $display("FAIL tmo_regs got=%h exp=0", regs_out); end
    endtask

    task automatic test_reserved();
        do_reset();
        tick(1, 8'h90); tick(0, 0); tick(1, 8'h01); tick(0, 0);
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL rsvd_err got=%0d exp=2", err_count); end
        tick(1, 8'h88); tick(0, 0); tick(1, 8'h01); tick(0, 0);
        total++; if (err_count !== 8'd4) begin bad++; $display("FAIL chan_err got=%0d exp=4", err_count); end
        total++; if (regs_out !== '0) begin bad++; $display("FAIL rsvd_regs got=%h exp=0", regs_out); end
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL rsvd_chg got=%b exp=00", reg_change); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 8'h12); tick(0, 0); tick(1, 8'h87); tick(0, 0); tick(1, 8'h11); tick(0, 0); tick(0, 0);
        total++; if (reg_change !== 2'b10) begin bad++; $display("FAIL ar_pre got=%b exp=10", reg_change); end
        tick(1, 8'h83); tick(0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (regs_out !== '0) begin bad++; $display("FAIL ar_regs got=%h exp=0", regs_out); end
        total++; if (reg_change !== '0) begin bad++; $display("FAIL ar_chg got=%b exp=0", reg_change); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL ar_err got=%0d exp=0", err_count); end
        @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
        tick(1, 8'h08); tick(0, 0); tick(0, 0);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL ar_orphan got=%0d exp=1", err_count); end
        total++; if (reg_change !== 2'b00) begin bad++; $display("FAIL ar_chg2 got=%b exp=00", reg_change); end
        total++; if (regs_out !== '0) begin bad++; $display("FAIL ar_regs2 got=%h exp=0", regs_out); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin tick(1, 8'h33); tick(0, 0); end
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_err got=%0d exp=255", err_count); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel, gap;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)
                b = {1'b1, 1'($urandom), 2'b00, 1'b0, 1'($urandom), 2'($urandom)};
            else if (sel < 6)
                b = 8'h80 | 8'($urandom);
            else
                b = {1'b0, 7'($urandom)};
            tick(1, b);
            gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                               : int'($urandom_range(1, 3));
            for (int g = 0; g <= gap; g++) begin
                total++; if (regs_out !== exp_regs()) begin bad++; $display("FAIL rand_regs i=%0d got=%h exp=%h", i, regs_out, exp_regs()); end
                total++; if (reg_change !== m_chg) begin bad++; $display("FAIL rand_chg i=%0d got=%b exp=%b", i, reg_change, m_chg); end
                total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL rand_err i=%0d got=%0d exp=%0d", i, err_count, m_err); end
                if (g < gap) tick(0, 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_trigger();
        test_back_to_back();
        test_restart();
        test_timeout();
        test_reserved();
        test_async_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
